// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    // Width of one CPU instruction word.
    localparam int INSTR_W = 16;

    // Width of one stream byte.
    localparam int BYTE_W = 8;

    // Loader sequencing: two header bytes, then word bodies two bytes at a time.
    typedef enum logic [2:0] {
        LEN_HI  = 3'd0,
        LEN_LO  = 3'd1,
        DATA_HI = 3'd2,
        DATA_LO = 3'd3,
        DONE    = 3'd4,
        ERROR   = 3'd5
    } ldr_state_t;

endpackage : imem_loader_pkg

// File: rtl/imem_loader_word_assembler.sv
// Pairs stream bytes into big-endian instruction words and produces the
// registered instruction-memory write triple (one-cycle strobe per word).
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc_hi_i,
    input  logic                 acc_lo_i,
    input  logic [BYTE_W-1:0]    byte_i,
    input  logic [ADDR_W-1:0]    addr_i,
    output logic                 wr_en_o,
    output logic [ADDR_W-1:0]    wr_addr_o,
    output logic [INSTR_W-1:0]   wr_data_o
);

    logic [BYTE_W-1:0]  hi_q;
    logic [BYTE_W-1:0]  hi_d;
    logic               wr_en_q;
    logic               wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic [INSTR_W-1:0] wr_data_q;
    logic [INSTR_W-1:0] wr_data_d;

    // Next-state: latch the high byte, and launch a write when the low byte lands.
    always_comb begin
        hi_d      = hi_q;
        wr_en_d   = acc_lo_i;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (acc_hi_i) begin
            hi_d = byte_i;
        end
        if (acc_lo_i) begin
            wr_addr_d = addr_i;
            wr_data_d = {hi_q, byte_i};
        end
    end

    // High-byte holding register; its content is meaningless until a high byte arrives.
    always_ff @(posedge clk) begin
        hi_q <= hi_d;
    end

    // Write triple register; reset drops any write that is still pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule : word_assembler

// File: rtl/imem_loader.sv
// Boot-time loader: receives a length-prefixed byte stream, writes the words
// into instruction memory from address 0, then releases the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [BYTE_W-1:0]    in_byte,
    output logic                 in_ready,
    input  logic                 reload,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [INSTR_W-1:0]   wr_data,
    output logic                 cpu_run,
    output logic                 load_err,
    output logic [ADDR_W-1:0]    words_loaded
);

    // Length checks are done on the full 16-bit header, widened to avoid any truncation.
    localparam logic [31:0] DEPTH_L = DEPTH;

    ldr_state_t        state_q;
    ldr_state_t        state_d;
    logic [15:0]       len_q;
    logic [15:0]       len_d;
    logic [ADDR_W-1:0] wl_q;
    logic [ADDR_W-1:0] wl_d;
    logic              cpu_run_q;
    logic              cpu_run_d;
    logic              load_err_q;
    logic              load_err_d;
    logic              rdy;
    logic              xfer;
    logic              acc_hi;
    logic              acc_lo;
    logic [15:0]       len_full;

    // Next-state, handshake and counter logic for the loader FSM.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wl_d     = wl_q;
        acc_hi   = 1'b0;
        acc_lo   = 1'b0;
        rdy      = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                   (state_q == DATA_HI) || (state_q == DATA_LO);
        xfer     = in_valid && rdy;
        len_full = {len_q[15:8], in_byte};

        case (state_q)
            LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_byte;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_byte;
                    if (len_full == 16'd0) begin
                        state_d = DONE;
                    end else if (32'(len_full) > DEPTH_L) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (xfer) begin
                    acc_hi  = 1'b1;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (xfer) begin
                    acc_lo = 1'b1;
                    wl_d   = wl_q + 1'b1;
                    if (32'(wl_d) == 32'(len_q)) begin
                        state_d = DONE;
                    end else begin
                        state_d = DATA_HI;
                    end
                end
            end
            DONE, ERROR: begin
                // Reload is only meaningful once a load has finished or failed.
                if (reload) begin
                    state_d = LEN_HI;
                    wl_d    = '0;
                end
            end
            default: begin
                state_d = LEN_HI;
            end
        endcase

        // The CPU is released one edge after DONE is reached, so the last write has landed.
        cpu_run_d  = (state_q == DONE) && !reload;
        load_err_d = (state_d == ERROR);
    end

    // State, length, word counter and status flags; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LEN_HI;
            len_q      <= '0;
            wl_q       <= '0;
            cpu_run_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wl_q       <= wl_d;
            cpu_run_q  <= cpu_run_d;
            load_err_q <= load_err_d;
        end
    end

    word_assembler #(
        .ADDR_W (ADDR_W)
    ) u_word_assembler (
        .clk       (clk),
        .rst       (rst),
        .acc_hi_i  (acc_hi),
        .acc_lo_i  (acc_lo),
        .byte_i    (in_byte),
        .addr_i    (wl_q),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data)
    );

    assign in_ready     = rdy;
    assign cpu_run      = cpu_run_q;
    assign load_err     = load_err_q;
    assign words_loaded = wl_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_byte = 8'h00;
    logic              reload = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_run;
    logic              load_err;
    logic [ADDR_W-1:0] words_loaded;

    int          errors = 0;
    int          checks = 0;
    logic        prev_wen = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    imem_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_byte      (in_byte),
        .in_ready     (in_ready),
        .reload       (reload),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge, writes checked against the scoreboard.
    task automatic tick();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            chk("wr_en_single_cycle", 32'(prev_wen), 32'd0);
            chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), {16'h0, e[31:16]});
                chk("wr_data", 32'(wr_data), {16'h0, e[15:0]});
            end
        end
        prev_wen = wr_en;
    endtask

    task automatic send_byte(input logic [7:0] b);
        chk("in_ready_at_byte", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_byte  = b;
        tick();
        in_valid = 1'b0;
        in_byte  = 8'hEE;
    endtask

    task automatic send_word(input logic [15:0] addr, input logic [15:0] w);
        exp_q.push_back({addr, w});
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_byte  = 8'hEE;
        tick();
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
        chk({tag, "_load_err"}, 32'(load_err), 32'd0);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic check_pending_empty(input string tag);
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Reset and reset values.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("reset");

        // Three-word load, back-to-back bytes.
        send_byte(8'h00);
        send_byte(8'h03);
        send_word(16'd0, 16'h1001);
        send_word(16'd1, 16'h2002);
        send_word(16'd2, 16'h3003);
        chk("t1_cpu_run_at_last_write", 32'(cpu_run), 32'd0);
        idle();
        chk("t1_cpu_run_after", 32'(cpu_run), 32'd1);
        chk("t1_wr_en_after", 32'(wr_en), 32'd0);
        chk("t1_words_loaded", 32'(words_loaded), 32'd3);
        chk("t1_in_ready", 32'(in_ready), 32'd0);
        check_pending_empty("t1");

        // Same stream with in_valid toggling every other cycle.
        pulse_reload();
        chk("t2_cpu_run_cleared", 32'(cpu_run), 32'd0);
        chk("t2_words_cleared", 32'(words_loaded), 32'd0);
        send_byte(8'h00); idle();
        send_byte(8'h03); idle();
        exp_q.push_back({16'd0, 16'h1001});
        exp_q.push_back({16'd1, 16'h2002});
        exp_q.push_back({16'd2, 16'h3003});
        send_byte(8'h10); idle(); send_byte(8'h01); idle();
        send_byte(8'h20); idle(); send_byte(8'h02); idle();
        send_byte(8'h30); idle(); send_byte(8'h03);
        idle();
        chk("t2_cpu_run", 32'(cpu_run), 32'd1);
        chk("t2_words_loaded", 32'(words_loaded), 32'd3);
        check_pending_empty("t2");

        // Zero-length header.
        pulse_reload();
        send_byte(8'h00);
        send_byte(8'h00);
        chk("t3_cpu_run_at_accept", 32'(cpu_run), 32'd0);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        idle();
        chk("t3_cpu_run", 32'(cpu_run), 32'd1);
        chk("t3_words_loaded", 32'(words_loaded), 32'd0);

        // Oversized header (257), then recovery via reload.
        pulse_reload();
        send_byte(8'h01);
        send_byte(8'h01);
        chk("t4_load_err", 32'(load_err), 32'd1);
        chk("t4_in_ready", 32'(in_ready), 32'd0);
        idle();
        chk("t4_cpu_run", 32'(cpu_run), 32'd0);
        chk("t4_load_err_held", 32'(load_err), 32'd1);
        pulse_reload();
        chk("t4_load_err_cleared", 32'(load_err), 32'd0);
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(16'd0, 16'hABCD);
        idle();
        chk("t4_cpu_run_after_reload", 32'(cpu_run), 32'd1);
        check_pending_empty("t4");

        // Reset in the middle of a load, with a byte offered on the reset edge.
        pulse_reload();
        send_byte(8'h00);
        send_byte(8'h04);
        send_word(16'd0, 16'h1122);
        send_byte(8'h33);
        check_pending_empty("t5_before_rst");
        chk("t5_words_before_rst", 32'(words_loaded), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h44;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_reset_values("t5_rst");
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(16'd0, 16'h4455);
        idle();
        chk("t5_cpu_run", 32'(cpu_run), 32'd1);
        check_pending_empty("t5");

        // Reload together with reset in DONE; reload ignored in DATA_HI.
        reload = 1'b1;
        rst    = 1'b1;
        tick();
        reload = 1'b0;
        rst    = 1'b0;
        check_reset_values("t6_rst_reload");
        send_byte(8'h00);
        send_byte(8'h02);
        pulse_reload();
        chk("t6_in_ready_data_hi", 32'(in_ready), 32'd1);
        send_word(16'd0, 16'h1234);
        send_word(16'd1, 16'h5678);
        idle();
        chk("t6_cpu_run", 32'(cpu_run), 32'd1);
        chk("t6_words_loaded", 32'(words_loaded), 32'd2);
        check_pending_empty("t6");

        // Largest accepted length: exactly DEPTH words.
        pulse_reload();
        send_byte(8'h01);
        send_byte(8'h00);
        chk("t7_no_err", 32'(load_err), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            send_word(16'(i), 16'(i * 3 + 16'h0100));
        end
        idle();
        chk("t7_cpu_run", 32'(cpu_run), 32'd1);
        chk("t7_words_loaded", 32'(words_loaded), 32'(DEPTH));
        chk("t7_load_err", 32'(load_err), 32'd0);
        check_pending_empty("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_imem_loader
